// File: rtl/ps2_keycode_rx.sv
// PS/2 scan-set-2 keyboard receiver: filters and deserialises frames, tracks E0/F0
// prefixes and holds the HID code of the last pressed mapped key.
module ps2_keycode_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] keycode,
  output logic        key_valid,
  output logic        frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  logic          clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
  logic          level_q, level_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [1:0]    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          ext_q, ext_d, brk_q, brk_d;
  logic [7:0]    kc_q, kc_d;
  logic          key_valid_q, key_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          sample;
  logic [7:0]    hid;

  // Zero means "not a mapped key"; no HID code used here is zero.
  function automatic logic [7:0] map_hid(input logic ext, input logic [7:0] b);
    logic [7:0] r;
    r = 8'h00;
    case ({ext, b})
      9'h01D: r = 8'h1A;
      9'h01B: r = 8'h16;
      9'h01C: r = 8'h04;
      9'h023: r = 8'h07;
      9'h029: r = 8'h2C;
      9'h175: r = 8'h52;
      9'h172: r = 8'h51;
      9'h16B: r = 8'h50;
      9'h174: r = 8'h4F;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  always_comb begin
    level_d     = level_q;
    filt_cnt_d  = '0;
    to_cnt_d    = to_cnt_q;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    ext_d       = ext_q;
    brk_d       = brk_q;
    kc_d        = kc_q;
    key_valid_d = 1'b0;
    frame_err_d = 1'b0;
    hid         = map_hid(ext_q, shift_q);

    if (clk_s2_q != level_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
        level_d = clk_s2_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
    sample = level_q & ~level_d;

    if (state_q == IDLE || sample) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
      to_cnt_d    = '0;
      state_d     = IDLE;
      frame_err_d = 1'b1;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end

    if (sample) begin
      case (state_q)
        IDLE: begin
          if (!data_s2_q) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          shift_d   = {data_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = data_s2_q;
          state_d = STOP;
        end
        default: begin
          state_d = IDLE;
          if (data_s2_q && (^{par_q, shift_q})) begin
            if (shift_q == 8'hE0) begin
              ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
              brk_d = 1'b1;
            end else begin
              ext_d = 1'b0;
              brk_d = 1'b0;
              if (hid != 8'h00) begin
                key_valid_d = 1'b1;
                if (!brk_q) kc_d = hid;
                else if (kc_q == hid) kc_d = 8'h00;
              end
            end
          end else begin
            frame_err_d = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      data_s1_q   <= 1'b1;
      data_s2_q   <= 1'b1;
      level_q     <= 1'b1;
      filt_cnt_q  <= '0;
      to_cnt_q    <= '0;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      kc_q        <= '0;
      key_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      clk_s1_q    <= ps2_clk;
      clk_s2_q    <= clk_s1_q;
      data_s1_q   <= ps2_data;
      data_s2_q   <= data_s1_q;
      level_q     <= level_d;
      filt_cnt_q  <= filt_cnt_d;
      to_cnt_q    <= to_cnt_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      kc_q        <= kc_d;
      key_valid_q <= key_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign keycode   = {8'h00, kc_q};
  assign key_valid = key_valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Bench for ps2_keycode_rx: directed vector table, hand-written corner sequences,
// then random byte streams checked against a keyboard-level reference model.
module tb_ps2_keycode_rx;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 150;
  localparam int HP         = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [15:0] keycode;
  logic        key_valid;
  logic        frame_err;

  int checks = 0;
  int errors = 0;
  int kv_cycles = 0;
  int fe_cycles = 0;

  ps2_keycode_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .Clk(clk), .Reset(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .keycode(keycode), .key_valid(key_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Pulse widths are measured in cycles so a stuck or double pulse shows up.
  always @(negedge clk) begin
    if (key_valid === 1'b1) kv_cycles++;
    if (frame_err === 1'b1) fe_cycles++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string      name;
    logic [7:0] b;
    bit         flip_par;
    bit         stop_val;
    logic [15:0] kc;
    int         kv;
    int         fe;
  } vec_t;

  vec_t vecs[$];

  logic [7:0]  hid_map[int];
  logic        m_ext, m_brk;
  logic [15:0] m_kc;

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      wait_cyc(HP);
      ps2_clk = 1'b0;
      wait_cyc(HP);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit stop_val);
    logic par;
    par = (~^b) ^ flip_par;
    send_bits({stop_val, par, b, 1'b0}, 11);
    wait_cyc(20);
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input string name, input logic [7:0] b, input bit flip_par,
                           input bit stop_val, input logic [15:0] kc, input int kv, input int fe);
    int kv0, fe0;
    kv0 = kv_cycles;
    fe0 = fe_cycles;
    send_frame(b, flip_par, stop_val);
    $display("%s: byte %02h par_flip=%0d stop=%0d -> keycode=%04h kv=%0d fe=%0d",
             name, b, flip_par, stop_val, keycode, kv_cycles - kv0, fe_cycles - fe0);
    check_val({name, " keycode"}, int'(keycode), int'(kc));
    check_val({name, " key_valid"}, kv_cycles - kv0, kv);
    check_val({name, " frame_err"}, fe_cycles - fe0, fe);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(2);
  endtask

  // Reference keyboard: prefix flags, one held key, map lookup by (extended, byte).
  task automatic model_byte(input logic [7:0] b, input bit good,
                            output int kv, output int fe);
    int key;
    kv = 0;
    fe = good ? 0 : 1;
    if (good) begin
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else begin
        key = (m_ext ? 256 : 0) + int'(b);
        if (hid_map.exists(key)) begin
          kv = 1;
          if (!m_brk) m_kc = {8'h00, hid_map[key]};
          else if (m_kc == {8'h00, hid_map[key]}) m_kc = 16'h0000;
        end
        m_ext = 1'b0;
        m_brk = 1'b0;
      end
    end
  endtask

  initial begin
    logic [7:0] pool[12];
    logic [7:0] b;
    bit flip;
    int ekv, efe, kv0;

    hid_map[8'h1D] = 8'h1A; hid_map[8'h1B] = 8'h16; hid_map[8'h1C] = 8'h04;
    hid_map[8'h23] = 8'h07; hid_map[8'h29] = 8'h2C;
    hid_map[256 + 8'h75] = 8'h52; hid_map[256 + 8'h72] = 8'h51;
    hid_map[256 + 8'h6B] = 8'h50; hid_map[256 + 8'h74] = 8'h4F;

    vecs.push_back('{"make W",        8'h1D, 0, 1, 16'h001A, 1, 0});
    vecs.push_back('{"F0 prefix",     8'hF0, 0, 1, 16'h001A, 0, 0});
    vecs.push_back('{"break W",       8'h1D, 0, 1, 16'h0000, 1, 0});
    vecs.push_back('{"E0 prefix",     8'hE0, 0, 1, 16'h0000, 0, 0});
    vecs.push_back('{"make up",       8'h75, 0, 1, 16'h0052, 1, 0});
    vecs.push_back('{"E0 prefix",     8'hE0, 0, 1, 16'h0052, 0, 0});
    vecs.push_back('{"F0 prefix",     8'hF0, 0, 1, 16'h0052, 0, 0});
    vecs.push_back('{"break up",      8'h75, 0, 1, 16'h0000, 1, 0});
    vecs.push_back('{"plain 75",      8'h75, 0, 1, 16'h0000, 0, 0});
    vecs.push_back('{"make A",        8'h1C, 0, 1, 16'h0004, 1, 0});
    vecs.push_back('{"make D",        8'h23, 0, 1, 16'h0007, 1, 0});
    vecs.push_back('{"F0 prefix",     8'hF0, 0, 1, 16'h0007, 0, 0});
    vecs.push_back('{"break A",       8'h1C, 0, 1, 16'h0007, 1, 0});
    vecs.push_back('{"F0 prefix",     8'hF0, 0, 1, 16'h0007, 0, 0});
    vecs.push_back('{"break D",       8'h23, 0, 1, 16'h0000, 1, 0});
    vecs.push_back('{"bad parity",    8'h1D, 1, 1, 16'h0000, 0, 1});
    vecs.push_back('{"bad stop",      8'h1D, 0, 0, 16'h0000, 0, 1});
    vecs.push_back('{"bad par+stop",  8'h1D, 1, 0, 16'h0000, 0, 1});
    vecs.push_back('{"make space",    8'h29, 0, 1, 16'h002C, 1, 0});
    vecs.push_back('{"repeat space",  8'h29, 0, 1, 16'h002C, 1, 0});
    vecs.push_back('{"F0 prefix",     8'hF0, 0, 1, 16'h002C, 0, 0});
    vecs.push_back('{"break space",   8'h29, 0, 1, 16'h0000, 1, 0});

    rst_n = 1'b0;
    wait_cyc(4);
    $display("reset: keycode=%04h key_valid=%0d frame_err=%0d", keycode, key_valid, frame_err);
    check_val("reset keycode", int'(keycode), 0);
    check_val("reset key_valid", int'(key_valid), 0);
    check_val("reset frame_err", int'(frame_err), 0);
    rst_n = 1'b1;
    wait_cyc(4);

    foreach (vecs[i])
      run_frame(vecs[i].name, vecs[i].b, vecs[i].flip_par, vecs[i].stop_val,
                vecs[i].kc, vecs[i].kv, vecs[i].fe);

    // Timeout: start bit plus five data bits, then silence.
    kv0 = fe_cycles;
    send_bits({3'b111, 8'h1B, 1'b0}, 6);
    wait_cyc(TIMEOUT + 1 + 40);
    $display("timeout: frame_err cycles=%0d keycode=%04h", fe_cycles - kv0, keycode);
    check_val("timeout frame_err", fe_cycles - kv0, 1);
    check_val("timeout keycode", int'(keycode), 0);
    run_frame("after timeout", 8'h1B, 0, 1, 16'h0016, 1, 0);

    // Short ps2_clk glitch with data low must not start a frame.
    ps2_data = 1'b0;
    wait_cyc(HP);
    ps2_clk = 1'b0;
    wait_cyc(FILTER_LEN - 2);
    ps2_clk = 1'b1;
    wait_cyc(HP);
    ps2_data = 1'b1;
    wait_cyc(HP);
    run_frame("after glitch", 8'h1D, 0, 1, 16'h001A, 1, 0);

    // Reset pulse in the middle of a frame.
    send_bits({3'b111, 8'h1C, 1'b0}, 4);
    rst_n = 1'b0;
    wait_cyc(1);
    rst_n = 1'b1;
    wait_cyc(1);
    $display("mid-frame reset: keycode=%04h", keycode);
    check_val("mid reset keycode", int'(keycode), 0);
    wait_cyc(HP);
    run_frame("after reset", 8'h1D, 0, 1, 16'h001A, 1, 0);

    // Random byte stream against the reference model.
    do_reset();
    m_ext = 1'b0;
    m_brk = 1'b0;
    m_kc  = 16'h0000;
    pool = '{8'hE0, 8'hF0, 8'hF0, 8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29, 8'h75, 8'h72, 8'h6B, 8'h74};
    for (int n = 0; n < 100; n++) begin
      if ($urandom_range(0, 7) == 0) b = 8'($urandom);
      else b = pool[$urandom_range(0, 11)];
      if (n < 3) begin
        b = pool[n + 3];
      end
      flip = ($urandom_range(0, 9) == 0);
      model_byte(b, !flip, ekv, efe);
      run_frame("random", b, flip, 1'b1, m_kc, ekv, efe);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
